// File: rtl/vertex_transform_if.sv
`default_nettype none
// ============================================================================
// vertex_transform_if : vertex stream and matrix-load bus for vertex_transform
// Revision 1.0
// ============================================================================
interface vertex_transform_if #(
  parameter int WIDTH = 32,
  parameter int DIM   = 4
);
  localparam int AW = $clog2(DIM * DIM);

  logic                       mat_we;
  logic [AW-1:0]              mat_addr;
  logic [WIDTH-1:0]           mat_data;
  logic                       mat_commit;
  logic                       affine_in;
  logic [DIM-1:0][WIDTH-1:0]  pos;
  logic                       valid_in;
  logic                       ready_out;
  logic [DIM-1:0][WIDTH-1:0]  new_pos;
  logic                       valid_out;
  logic                       ready_in;

  modport master (
    output mat_we, mat_addr, mat_data, mat_commit, affine_in, pos, valid_in, ready_in,
    input  ready_out, new_pos, valid_out
  );

  modport slave (
    input  mat_we, mat_addr, mat_data, mat_commit, affine_in, pos, valid_in, ready_in,
    output ready_out, new_pos, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/vertex_transform.sv
`default_nettype none
// ============================================================================
// vertex_transform : 2-stage saturating fixed-point DIMxDIM matrix-vector transform
// Revision 1.0
// ============================================================================
module vertex_transform #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16,
  parameter int DIM   = 4
) (
  input wire                 clk_in,
  input wire                 rst_in,
  vertex_transform_if.slave  bus
);
  localparam int NUM = DIM * DIM;
  localparam int PW  = 2 * WIDTH;
  localparam int SW  = PW + $clog2(DIM);
  localparam logic signed [WIDTH-1:0] ONE     = WIDTH'(1) << FRAC;
  localparam logic signed [SW-1:0]    ROUND   = SW'(1) << (FRAC - 1);
  localparam logic signed [SW-1:0]    SAT_MAX = SW'({1'b0, {(WIDTH-1){1'b1}}});
  localparam logic signed [SW-1:0]    SAT_MIN = ~SAT_MAX;

  logic signed [WIDTH-1:0]   shadow [NUM];
  logic signed [WIDTH-1:0]   active [NUM];
  logic signed [WIDTH-1:0]   vin    [DIM];
  logic signed [PW-1:0]      prod   [DIM][DIM];
  logic                      s1_valid;
  logic                      s1_affine;
  logic                      out_valid;
  logic [DIM-1:0][WIDTH-1:0] out_pos;
  logic [DIM-1:0][WIDTH-1:0] result;
  logic signed [SW-1:0]      acc;
  logic signed [SW-1:0]      shifted;
  logic                      en;

  assign en            = !out_valid || bus.ready_in;
  assign bus.ready_out = en;
  assign bus.valid_out = out_valid;
  assign bus.new_pos   = out_pos;

  // Commit copies the shadow as it was before any same-cycle write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM; k++) begin
        shadow[k] <= (k / DIM == k % DIM) ? ONE : '0;
        active[k] <= (k / DIM == k % DIM) ? ONE : '0;
      end
    end else begin
      if (bus.mat_commit) begin
        active <= shadow;
      end
      if (bus.mat_we && (int'(bus.mat_addr) < NUM)) begin
        shadow[bus.mat_addr] <= bus.mat_data;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < DIM; j++) begin
      vin[j] = bus.pos[j];
    end
    if (bus.affine_in) begin
      vin[0] = ONE;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      s1_valid  <= 1'b0;
      s1_affine <= 1'b0;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          prod[i][j] <= '0;
        end
      end
    end else if (en) begin
      s1_valid  <= bus.valid_in;
      s1_affine <= bus.affine_in;
      for (int i = 0; i < DIM; i++) begin
        for (int j = 0; j < DIM; j++) begin
          prod[i][j] <= PW'(active[i*DIM+j]) * PW'(vin[j]);
        end
      end
    end
  end

  // Accumulator starts at the rounding constant so the shift rounds half up.
  always_comb begin
    result  = '0;
    acc     = '0;
    shifted = '0;
    for (int i = 0; i < DIM; i++) begin
      acc = ROUND;
      for (int j = 0; j < DIM; j++) begin
        acc = acc + SW'(prod[i][j]);
      end
      shifted = acc >>> FRAC;
      if (shifted > SAT_MAX) begin
        result[i] = SAT_MAX[WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
        result[i] = SAT_MIN[WIDTH-1:0];
      end else begin
        result[i] = shifted[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_valid <= 1'b0;
      out_pos   <= '0;
    end else if (en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pos <= result;
        if (s1_affine) begin
          out_pos[0] <= ONE;
        end
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_vertex_transform.sv
`default_nettype none
// ============================================================================
// tb_vertex_transform : vector table plus queue scoreboard for vertex_transform
// Revision 1.0
// ============================================================================
module tb_vertex_transform;
  localparam int W = 32;
  localparam int F = 16;
  localparam int D = 4;
  localparam int N = D * D;
  localparam logic [31:0]  ONE    = 32'h0001_0000;
  localparam logic [127:0] ID_POS = {32'h0001_0000, 32'h0002_0000, 32'hFFFF_0000, 32'h0001_0000};
  localparam logic [127:0] X1     = {32'h0001_0000, 96'b0};
  localparam logic [127:0] XW1    = {32'h0001_0000, 32'h0, 32'h0, 32'h0001_0000};

  typedef struct {
    int           mid;
    logic         aff;
    logic [127:0] pos;
    logic [127:0] exp;
    string        name;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vertex_transform_if #(.WIDTH(W), .DIM(D)) bus();

  vertex_transform #(.WIDTH(W), .FRAC(F), .DIM(D)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  int           checks = 0;
  int           errors = 0;
  int           total_out = 0;
  logic [127:0] sb  [$];
  logic [127:0] cap [$];
  logic [31:0]  m_sh  [N];
  logic [31:0]  m_act [N];
  logic         prev_stall = 1'b0;
  logic [127:0] prev_pos = '0;
  vec_t         vecs [12];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [127:0] p, input logic aff);
    logic [127:0]        r;
    logic signed [127:0] s;
    logic signed [31:0]  a;
    logic signed [31:0]  b;
    r = '0;
    for (int i = 0; i < D; i++) begin
      s = 128'sd1 <<< (F - 1);
      for (int j = 0; j < D; j++) begin
        a = m_act[i*D+j];
        b = (j == 0 && aff) ? ONE : p[j*32 +: 32];
        s = s + 128'(a) * 128'(b);
      end
      s = s >>> F;
      if (s > 128'sd2147483647)       r[i*32 +: 32] = 32'h7FFF_FFFF;
      else if (s < -128'sd2147483648) r[i*32 +: 32] = 32'h8000_0000;
      else                            r[i*32 +: 32] = s[31:0];
    end
    if (aff) r[31:0] = ONE;
    return r;
  endfunction

  function automatic logic [31:0] mat_val(input int id, input int k);
    logic [31:0] v;
    v = (k / D == k % D) ? ONE : 32'h0;
    case (id)
      1: begin
        if (k == 12) v = 32'h0002_0000;
        if (k == 8)  v = 32'h0003_0000;
        if (k == 4)  v = 32'h0004_0000;
      end
      2: if (k == 15) v = 32'h7FFF_0000;
      3: if (k == 15) v = 32'h0000_8000;
      default: ;
    endcase
    return v;
  endfunction

  // Negedge monitor: reference matrix tracking, scoreboard and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      prev_stall = 1'b0;
      for (int k = 0; k < N; k++) begin
        m_sh[k]  = (k / D == k % D) ? ONE : 32'h0;
        m_act[k] = (k / D == k % D) ? ONE : 32'h0;
      end
    end else begin
      if (prev_stall) begin
        check("stall_hold_pos", bus.new_pos, prev_pos);
        check("stall_hold_valid", {127'b0, bus.valid_out}, 128'd1);
      end
      if (bus.valid_out && bus.ready_in) begin
        total_out++;
        cap.push_back(bus.new_pos);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: got unexpected output %h expected none", bus.new_pos);
        end else begin
          check("scoreboard", bus.new_pos, sb.pop_front());
        end
      end
      if (bus.valid_in && bus.ready_out) sb.push_back(model(bus.pos, bus.affine_in));
      if (bus.mat_commit) m_act = m_sh;
      if (bus.mat_we) m_sh[bus.mat_addr] = bus.mat_data;
      prev_stall = bus.valid_out && !bus.ready_in;
      prev_pos   = bus.new_pos;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] p, input logic aff);
    logic ok;
    ok = 1'b0;
    bus.pos       = p;
    bus.affine_in = aff;
    bus.valid_in  = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = bus.ready_out;
      tick();
    end
    bus.valid_in = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got ready_out low for 200 cycles expected acceptance");
    end
  endtask

  task automatic expect_out(input string name, input logic [127:0] exp);
    for (int n = 0; n < 50 && cap.size() == 0; n++) @(posedge clk);
    #1;
    if (cap.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got no output expected %h", name, exp);
    end else begin
      check(name, cap.pop_front(), exp);
    end
  endtask

  task automatic wr(input int k, input logic [31:0] v);
    bus.mat_we   = 1'b1;
    bus.mat_addr = 4'(k);
    bus.mat_data = v;
    tick();
    bus.mat_we   = 1'b0;
  endtask

  task automatic commit_pulse();
    bus.mat_commit = 1'b1;
    tick();
    bus.mat_commit = 1'b0;
  endtask

  task automatic load_matrix(input int id);
    for (int k = 0; k < N; k++) wr(k, mat_val(id, k));
    commit_pulse();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cur;
    int base;
    int cnt;
    logic [31:0] expx;

    vecs[0]  = '{0, 1'b0, ID_POS, ID_POS, "identity"};
    vecs[1]  = '{1, 1'b0, XW1, {32'h0003_0000, 32'h0003_0000, 32'h0004_0000, 32'h0001_0000}, "translate"};
    vecs[2]  = '{1, 1'b0, {32'h0000_8000, 32'h0, 32'h0, 32'h0002_0000},
                 {32'h0004_8000, 32'h0006_0000, 32'h0008_0000, 32'h0002_0000}, "translate_w2"};
    vecs[3]  = '{1, 1'b1, {32'h0001_0000, 32'h0, 32'h0, 32'h1234_5678},
                 {32'h0003_0000, 32'h0003_0000, 32'h0004_0000, 32'h0001_0000}, "affine_translate"};
    vecs[4]  = '{2, 1'b0, {32'h0004_0000, 96'b0}, {32'h7FFF_FFFF, 96'b0}, "sat_pos"};
    vecs[5]  = '{2, 1'b0, {32'hFFFC_0000, 96'b0}, {32'h8000_0000, 96'b0}, "sat_neg"};
    vecs[6]  = '{2, 1'b0, X1, {32'h7FFF_0000, 96'b0}, "sat_none"};
    vecs[7]  = '{3, 1'b0, {32'h0000_0001, 96'b0}, {32'h0000_0001, 96'b0}, "round_half_p1"};
    vecs[8]  = '{3, 1'b0, {32'hFFFF_FFFF, 96'b0}, {32'h0000_0000, 96'b0}, "round_half_m1"};
    vecs[9]  = '{3, 1'b0, {32'h0000_0003, 96'b0}, {32'h0000_0002, 96'b0}, "round_half_p3"};
    vecs[10] = '{3, 1'b0, {32'hFFFF_FFFD, 96'b0}, {32'hFFFF_FFFF, 96'b0}, "round_half_m3"};
    vecs[11] = '{0, 1'b1, {32'h5, 32'h6, 32'h7, 32'h0}, {32'h5, 32'h6, 32'h7, 32'h0001_0000}, "affine_identity"};

    bus.mat_we     = 1'b0;
    bus.mat_addr   = '0;
    bus.mat_data   = '0;
    bus.mat_commit = 1'b0;
    bus.affine_in  = 1'b0;
    bus.pos        = '0;
    bus.valid_in   = 1'b0;
    bus.ready_in   = 1'b1;

    tick();
    tick();
    check("reset_valid_out", {127'b0, bus.valid_out}, 128'd0);
    check("reset_new_pos", bus.new_pos, 128'd0);
    check("reset_ready_out", {127'b0, bus.ready_out}, 128'd1);
    rst = 1'b0;
    tick();

    // Two-cycle latency, single-cycle output pulse.
    cap.delete();
    send(ID_POS, 1'b0);
    check("lat_c1_valid", {127'b0, bus.valid_out}, 128'd0);
    tick();
    check("lat_c2_valid", {127'b0, bus.valid_out}, 128'd1);
    check("lat_c2_pos", bus.new_pos, ID_POS);
    tick();
    check("lat_c3_valid", {127'b0, bus.valid_out}, 128'd0);

    cur = 0;
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].mid != cur) begin
        load_matrix(vecs[i].mid);
        cur = vecs[i].mid;
      end
      cap.delete();
      send(vecs[i].pos, vecs[i].aff);
      expect_out(vecs[i].name, vecs[i].exp);
    end

    // Random backpressure on a streamed burst.
    load_matrix(1);
    base = total_out;
    cap.delete();
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          send({32'(k * 32'h0001_1000 + 32'h0001_0000), 32'(k << 16), 32'(-(k << 16)),
                32'(32'h0001_0000 + k * 32'h100)}, 1'b0);
        end
      end
      begin
        for (int c = 0; c < 400 && total_out < base + 8; c++) begin
          bus.ready_in = 1'($urandom_range(0, 1));
          tick();
        end
        bus.ready_in = 1'b1;
      end
    join
    repeat (5) tick();
    check("bp_count", 128'(total_out - base), 128'd8);
    check("bp_sb_empty", 128'(sb.size()), 128'd0);

    // Commit lands in the acceptance cycle of vertex 3.
    load_matrix(0);
    wr(15, 32'h0002_0000);
    cap.delete();
    for (int k = 0; k < 8; k++) begin
      if (k == 3) bus.mat_commit = 1'b1;
      send({32'((k + 1) << 16), 32'h0, 32'h0, ONE}, 1'b0);
      bus.mat_commit = 1'b0;
    end
    for (int n = 0; n < 50 && cap.size() < 8; n++) tick();
    if (cap.size() < 8) begin
      checks++;
      errors++;
      $display("FAIL commit_bnd_count: got %0d outputs expected 8", cap.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        expx = (k <= 3) ? 32'((k + 1) << 16) : 32'((k + 1) << 17);
        check("commit_bnd_x", {96'b0, cap[k][127:96]}, {96'b0, expx});
      end
    end

    // Same-cycle write and commit: write stays in shadow.
    bus.mat_we     = 1'b1;
    bus.mat_addr   = 4'd15;
    bus.mat_data   = 32'h0003_0000;
    bus.mat_commit = 1'b1;
    tick();
    bus.mat_we     = 1'b0;
    bus.mat_commit = 1'b0;
    cap.delete();
    send(X1, 1'b0);
    expect_out("wc_same_cycle", {32'h0002_0000, 96'b0});
    commit_pulse();
    cap.delete();
    send(X1, 1'b0);
    expect_out("wc_next_commit", {32'h0003_0000, 96'b0});

    // Reset with two vertices in flight.
    load_matrix(1);
    bus.ready_in = 1'b0;
    send(ID_POS, 1'b0);
    send({32'h0002_0000, 96'b0}, 1'b0);
    check("mid_inflight_valid", {127'b0, bus.valid_out}, 128'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_async_valid", {127'b0, bus.valid_out}, 128'd0);
    check("rst_async_pos", bus.new_pos, 128'd0);
    check("rst_async_ready", {127'b0, bus.ready_out}, 128'd1);
    tick();
    tick();
    rst = 1'b0;
    bus.ready_in = 1'b1;
    base = total_out;
    cnt = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (bus.valid_out) cnt++;
    end
    check("rst_no_output", 128'(cnt), 128'd0);
    check("rst_no_transfer", 128'(total_out - base), 128'd0);
    cap.delete();
    send(XW1, 1'b0);
    expect_out("rst_identity", XW1);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
